cpu_busctl: RTL

CPU-side bus cycle controller that sits directly upstream of the DRAM controller. It decodes each 68030 bus cycle into one of RAM, ROM, IO or unmapped, and drives the active-low select that the DRAM controller samples as cpu_nRAMSEL. It terminates ROM and IO cycles itself with fixed wait states. A watchdog asserts BERR on any cycle that nobody acknowledges. It also implements the post-reset ROM overlay at address 0 so the CPU can fetch its reset vectors.

---
 rtl/cpu_busctl_if.sv | 26 ++
 rtl/cpu_busctl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/cpu_busctl_if.sv
// CPU-side bus bundle between the 68030 bus and the cycle controller.
// The controller takes the slave view; the CPU/board side takes the master view.
interface cpu_busctl_if;
  logic        cpu_nAS;
  logic        RnW;
  logic [2:0]  FC;
  logic [11:0] ADDR;
  logic        ram_dsack;
  logic        nRAMSEL;
  logic        nROMSEL;
  logic        nIOSEL;
  logic        DSACK0;
  logic        DSACK1;
  logic        BERR;
  logic        OVERLAY;

  modport slave (
    input  cpu_nAS, RnW, FC, ADDR, ram_dsack,
    output nRAMSEL, nROMSEL, nIOSEL, DSACK0, DSACK1, BERR, OVERLAY
  );

  modport master (
    output cpu_nAS, RnW, FC, ADDR, ram_dsack,
    input  nRAMSEL, nROMSEL, nIOSEL, DSACK0, DSACK1, BERR, OVERLAY
  );
endinterface

// File: rtl/cpu_busctl.sv
// 68030 bus cycle controller: region decode, ROM/IO wait-state termination,
// BERR watchdog and the post-reset ROM overlay at address 0.
module cpu_busctl #(
  parameter int ROM_WAIT     = 4,
  parameter int IO_WAIT      = 6,
  parameter int BERR_TIMEOUT = 64
) (
  input  logic         CLK,
  input  logic         RST,
  cpu_busctl_if.slave  bus
);

  typedef enum logic [2:0] {ST_IDLE, ST_SEL, ST_ACK, ST_BERR, ST_END} state_t;
  typedef enum logic [1:0] {RGN_NONE, RGN_RAM, RGN_ROM, RGN_IO} region_t;

  localparam logic [7:0] ROM_LAST     = 8'(ROM_WAIT - 1);
  localparam logic [7:0] IO_LAST      = 8'(IO_WAIT - 1);
  localparam logic [7:0] TIMEOUT_LAST = 8'(BERR_TIMEOUT - 1);

  logic       as_meta, as_sync;
  state_t     state_q, state_d;
  region_t    region_q, region_d, decoded;
  logic       native_rom;
  logic       rnw_q, rnw_d;
  logic [7:0] count_q, count_d;
  logic       nram_q, nram_d;
  logic       nrom_q, nrom_d;
  logic       nio_q, nio_d;
  logic       dsack0_q, dsack0_d;
  logic       dsack1_q, dsack1_d;
  logic       berr_q, berr_d;
  logic       overlay_q, overlay_d;

  // Overlay steers reads at the bottom 256 MB to ROM; writes still reach RAM.
  always_comb begin
    decoded    = RGN_NONE;
    native_rom = 1'b0;
    if (bus.FC != 3'b111) begin
      if (bus.ADDR[11:8] == 4'h0) begin
        decoded = (overlay_q && bus.RnW) ? RGN_ROM : RGN_RAM;
      end else if (bus.ADDR == 12'hFFE) begin
        decoded    = RGN_ROM;
        native_rom = 1'b1;
      end else if (bus.ADDR == 12'hFFF) begin
        decoded = RGN_IO;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    region_d  = region_q;
    rnw_d     = rnw_q;
    count_d   = count_q;
    nram_d    = nram_q;
    nrom_d    = nrom_q;
    nio_d     = nio_q;
    dsack0_d  = dsack0_q;
    dsack1_d  = dsack1_q;
    berr_d    = berr_q;
    overlay_d = overlay_q;

    case (state_q)
      ST_IDLE: begin
        if (as_sync) begin
          state_d  = ST_SEL;
          count_d  = 8'd0;
          region_d = decoded;
          rnw_d    = bus.RnW;
          nram_d   = (decoded != RGN_RAM);
          nrom_d   = (decoded != RGN_ROM);
          nio_d    = (decoded != RGN_IO);
          if (native_rom) overlay_d = 1'b0;
        end
      end

      ST_SEL: begin
        if (count_q != 8'hFF) count_d = count_q + 8'd1;
        if (!as_sync) begin
          state_d  = ST_END;
          nram_d   = 1'b1;
          nrom_d   = 1'b1;
          nio_d    = 1'b1;
          dsack0_d = 1'b0;
          dsack1_d = 1'b0;
          berr_d   = 1'b0;
        end else begin
          case (region_q)
            RGN_ROM: begin
              if (count_q == ROM_LAST) begin
                if (rnw_q) begin
                  dsack0_d = 1'b1;
                  dsack1_d = 1'b1;
                  state_d  = ST_ACK;
                end else begin
                  berr_d  = 1'b1;
                  state_d = ST_BERR;
                end
              end
            end
            RGN_IO: begin
              if (count_q == IO_LAST) begin
                dsack0_d = 1'b1;
                state_d  = ST_ACK;
              end
            end
            RGN_RAM: begin
              if (bus.ram_dsack) state_d = ST_ACK;
            end
            default: ;
          endcase
          // An acknowledge landing on the timeout cycle has already moved us out of SEL.
          if (state_d == ST_SEL && count_q == TIMEOUT_LAST) begin
            berr_d  = 1'b1;
            state_d = ST_BERR;
          end
        end
      end

      ST_ACK, ST_BERR: begin
        if (!as_sync) begin
          state_d  = ST_END;
          nram_d   = 1'b1;
          nrom_d   = 1'b1;
          nio_d    = 1'b1;
          dsack0_d = 1'b0;
          dsack1_d = 1'b0;
          berr_d   = 1'b0;
        end
      end

      ST_END: begin
        state_d  = ST_IDLE;
        nram_d   = 1'b1;
        nrom_d   = 1'b1;
        nio_d    = 1'b1;
        dsack0_d = 1'b0;
        dsack1_d = 1'b0;
        berr_d   = 1'b0;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      as_meta   <= 1'b0;
      as_sync   <= 1'b0;
      state_q   <= ST_IDLE;
      region_q  <= RGN_NONE;
      rnw_q     <= 1'b1;
      count_q   <= 8'd0;
      nram_q    <= 1'b1;
      nrom_q    <= 1'b1;
      nio_q     <= 1'b1;
      dsack0_q  <= 1'b0;
      dsack1_q  <= 1'b0;
      berr_q    <= 1'b0;
      overlay_q <= 1'b1;
    end else begin
      as_meta   <= ~bus.cpu_nAS;
      as_sync   <= as_meta;
      state_q   <= state_d;
      region_q  <= region_d;
      rnw_q     <= rnw_d;
      count_q   <= count_d;
      nram_q    <= nram_d;
      nrom_q    <= nrom_d;
      nio_q     <= nio_d;
      dsack0_q  <= dsack0_d;
      dsack1_q  <= dsack1_d;
      berr_q    <= berr_d;
      overlay_q <= overlay_d;
    end
  end

  assign bus.nRAMSEL = nram_q;
  assign bus.nROMSEL = nrom_q;
  assign bus.nIOSEL  = nio_q;
  assign bus.DSACK0  = dsack0_q;
  assign bus.DSACK1  = dsack1_q;
  assign bus.BERR    = berr_q;
  assign bus.OVERLAY = overlay_q;

endmodule
